sr_ctx_seq: RTL and testbench

Context save/restore sequencer for the special-register (SR) file. It is the reader/writer master on the SR file's read and write ports.
- Save: walks every SR entry and streams it to memory over a valid/ready write channel.
- Restore: fetches every entry from memory over a request/response read channel and writes it back into the SR file.
- Sits beside the SR file. The parent muxes the SR ports to this block while ow_busy is high and stalls the pipeline.

---
 rtl/sr_ctx_seq_pkg.sv | 20 ++
 rtl/sr_ctx_seq_if.sv | 27 ++
 rtl/sr_ctx_seq.sv | 104 ++++++++++
 tb/tb_sr_ctx_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ctx_seq_pkg.sv
// Shared sizes and sequencer state encoding for the SR context save/restore block.
package sr_ctx_seq_pkg;

  localparam int unsigned HBIT_DATA   = 23;
  localparam int unsigned HBIT_TGT_GP = 3;
  localparam int unsigned HBIT_SR     = 15;

  localparam int unsigned DATA_W     = HBIT_DATA + 1;
  localparam int unsigned IDX_W      = HBIT_TGT_GP + 1;
  localparam int unsigned CTX_ADDR_W = 24;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_SAVE  = 3'd1,
    SEQ_RREQ  = 3'd2,
    SEQ_RWAIT = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/sr_ctx_seq_if.sv
// Memory-side channels of the context sequencer: valid/ready save writes, req/resp restore reads.
interface sr_ctx_seq_if
  import sr_ctx_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = CTX_ADDR_W
) ();

  logic              wvalid;
  logic              wready;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              rreq;
  logic [ADDR_W-1:0] raddr;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output wvalid, waddr, wdata, rreq, raddr,
    input  wready, rvalid, rdata
  );

  modport slave (
    input  wvalid, waddr, wdata, rreq, raddr,
    output wready, rvalid, rdata
  );

endinterface

// File: rtl/sr_ctx_seq.sv
// Walks the SR file, streaming each entry to memory (save) or reloading it from memory (restore).
module sr_ctx_seq
  import sr_ctx_seq_pkg::*;
#(
  parameter int unsigned SR_COUNT = HBIT_SR + 1,
  parameter int unsigned ADDR_W   = CTX_ADDR_W
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_start_save,
  input  logic              iw_start_restore,
  input  logic [ADDR_W-1:0] iw_base_addr,
  output logic              ow_busy,
  output logic              ow_done,
  output logic [IDX_W-1:0]  ow_sr_read_addr,
  input  logic [DATA_W-1:0] iw_sr_read_data,
  output logic [IDX_W-1:0]  ow_sr_write_addr,
  output logic [DATA_W-1:0] ow_sr_write_data,
  output logic              ow_sr_write_enable,
  sr_ctx_seq_if.master      mem
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SR_COUNT - 1);

  seq_state_e        state, state_nx;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] cur_addr;
  logic              last;

  // Context area address wraps modulo 2^ADDR_W.
  assign cur_addr = r_base + ADDR_W'(r_idx);
  assign last     = (r_idx == LAST_IDX);

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state  <= SEQ_IDLE;
      r_idx  <= '0;
      r_base <= '0;
    end else begin
      state <= state_nx;
      case (state)
        SEQ_IDLE: begin
          if (iw_start_save || iw_start_restore) begin
            r_base <= iw_base_addr;
            r_idx  <= '0;
          end
        end
        SEQ_SAVE:  if (mem.wready && !last) r_idx <= r_idx + 1'b1;
        SEQ_RWAIT: if (mem.rvalid && !last) r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx           = state;
    ow_busy            = (state != SEQ_IDLE);
    ow_done            = 1'b0;
    ow_sr_read_addr    = '0;
    ow_sr_write_addr   = '0;
    ow_sr_write_data   = '0;
    ow_sr_write_enable = 1'b0;
    mem.wvalid         = 1'b0;
    mem.waddr          = '0;
    mem.wdata          = '0;
    mem.rreq           = 1'b0;
    mem.raddr          = '0;
    case (state)
      SEQ_IDLE: begin
        // Save takes priority when both starts arrive together.
        if (iw_start_save)         state_nx = SEQ_SAVE;
        else if (iw_start_restore) state_nx = SEQ_RREQ;
      end
      SEQ_SAVE: begin
        ow_sr_read_addr = r_idx;
        mem.wvalid      = 1'b1;
        mem.waddr       = cur_addr;
        mem.wdata       = iw_sr_read_data;
        if (mem.wready) state_nx = last ? SEQ_DONE : SEQ_SAVE;
      end
      SEQ_RREQ: begin
        mem.rreq  = 1'b1;
        mem.raddr = cur_addr;
        state_nx  = SEQ_RWAIT;
      end
      SEQ_RWAIT: begin
        mem.raddr = cur_addr;
        if (mem.rvalid) begin
          ow_sr_write_enable = 1'b1;
          ow_sr_write_addr   = r_idx;
          ow_sr_write_data   = mem.rdata;
          state_nx           = last ? SEQ_DONE : SEQ_RREQ;
        end
      end
      SEQ_DONE: begin
        ow_done  = 1'b1;
        state_nx = SEQ_IDLE;
      end
      default: state_nx = SEQ_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sr_ctx_seq.sv
// Directed bench for sr_ctx_seq: save, stalled save, wrapping restore, stray rvalid, mid-restore reset.
module tb_sr_ctx_seq;
  import sr_ctx_seq_pkg::*;

  localparam int unsigned AW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_save;
  logic              start_restore;
  logic [AW-1:0]     base_addr;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  sr_read_addr;
  logic [DATA_W-1:0] sr_read_data;
  logic [IDX_W-1:0]  sr_write_addr;
  logic [DATA_W-1:0] sr_write_data;
  logic              sr_write_enable;
  logic [DATA_W-1:0] sr_model [16];

  int n_checks = 0;
  int n_errors = 0;

  sr_ctx_seq_if #(.ADDR_W(AW)) mem_if ();

  sr_ctx_seq #(.SR_COUNT(4), .ADDR_W(AW)) dut (
    .iw_clk             (clk),
    .iw_rst             (rst),
    .iw_start_save      (start_save),
    .iw_start_restore   (start_restore),
    .iw_base_addr       (base_addr),
    .ow_busy            (busy),
    .ow_done            (done),
    .ow_sr_read_addr    (sr_read_addr),
    .iw_sr_read_data    (sr_read_data),
    .ow_sr_write_addr   (sr_write_addr),
    .ow_sr_write_data   (sr_write_data),
    .ow_sr_write_enable (sr_write_enable),
    .mem                (mem_if)
  );

  always #5 clk = ~clk;

  assign sr_read_data = sr_model[sr_read_addr];

  always @(posedge clk) begin
    if (sr_write_enable) sr_model[sr_write_addr] <= sr_write_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0]     save_addr [4] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
  logic [DATA_W-1:0] save_data [4] = '{24'h11, 24'h22, 24'h33, 24'h44};
  logic [AW-1:0]     rst_addr  [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [DATA_W-1:0] rst_data  [4] = '{24'h0A, 24'h0B, 24'h0C, 24'h0D};
  logic [AW-1:0]     re_addr   [4] = '{16'h0300, 16'h0301, 16'h0302, 16'h0303};
  logic [DATA_W-1:0] re_data   [4] = '{24'h101, 24'h202, 24'h303, 24'h404};

  initial begin
    rst           = 1'b1;
    start_save    = 1'b0;
    start_restore = 1'b0;
    base_addr     = '0;
    mem_if.wready = 1'b1;
    mem_if.rvalid = 1'b0;
    mem_if.rdata  = '0;
    for (int i = 0; i < 16; i++) sr_model[i] = '0;
    sr_model[0] = 24'h11; sr_model[1] = 24'h22; sr_model[2] = 24'h33; sr_model[3] = 24'h44;

    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_wvalid", mem_if.wvalid, 0);
    check_eq("rst_rreq", mem_if.rreq, 0);
    check_eq("rst_we", sr_write_enable, 0);
    tick;
    rst = 1'b0;
    tick;

    // Save, wready tied high
    base_addr  = 16'h0100;
    start_save = 1'b1;
    check_eq("save_busy_pre", busy, 0);
    tick;
    start_save = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("save_busy", busy, 1);
      check_eq("save_wvalid", mem_if.wvalid, 1);
      check_eq("save_waddr", mem_if.waddr, save_addr[i]);
      check_eq("save_wdata", mem_if.wdata, save_data[i]);
      check_eq("save_we", sr_write_enable, 0);
      tick;
    end
    check_eq("save_done", done, 1);
    check_eq("save_done_busy", busy, 1);
    check_eq("save_done_wvalid", mem_if.wvalid, 0);
    tick;
    check_eq("save_idle_done", done, 0);
    check_eq("save_idle_busy", busy, 0);

    // Simultaneous starts, restore pulse mid-save, stall on beat 2
    start_save    = 1'b1;
    start_restore = 1'b1;
    tick;
    start_save    = 1'b0;
    start_restore = 1'b0;
    check_eq("both_wvalid", mem_if.wvalid, 1);
    check_eq("both_rreq", mem_if.rreq, 0);
    check_eq("both_waddr0", mem_if.waddr, 16'h0100);
    tick;
    check_eq("both_waddr1", mem_if.waddr, 16'h0101);
    start_restore = 1'b1;
    tick;
    start_restore = 1'b0;
    mem_if.wready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("stall_waddr", mem_if.waddr, 16'h0102);
      check_eq("stall_wdata", mem_if.wdata, 24'h33);
      check_eq("stall_wvalid", mem_if.wvalid, 1);
      check_eq("stall_rreq", mem_if.rreq, 0);
      tick;
    end
    mem_if.wready = 1'b1;
    check_eq("stall_rel_waddr", mem_if.waddr, 16'h0102);
    tick;
    check_eq("stall_b3_waddr", mem_if.waddr, 16'h0103);
    check_eq("stall_b3_wdata", mem_if.wdata, 24'h44);
    tick;
    check_eq("stall_done", done, 1);
    tick;
    check_eq("stall_idle_busy", busy, 0);
    check_eq("stall_idle_rreq", mem_if.rreq, 0);

    // Stray rvalid in IDLE
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 24'h77;
    #1;
    check_eq("idle_rvalid_we", sr_write_enable, 0);
    tick;
    check_eq("idle_rvalid_we2", sr_write_enable, 0);
    check_eq("idle_rvalid_busy", busy, 0);
    mem_if.rvalid = 1'b0;

    // Restore with wrapping base
    base_addr     = 16'hFFFE;
    start_restore = 1'b1;
    tick;
    start_restore = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("rest_rreq", mem_if.rreq, 1);
      check_eq("rest_raddr", mem_if.raddr, rst_addr[i]);
      check_eq("rest_we_rreq", sr_write_enable, 0);
      tick;
      check_eq("rest_rreq_low", mem_if.rreq, 0);
      check_eq("rest_raddr_hold", mem_if.raddr, rst_addr[i]);
      mem_if.rvalid = 1'b1;
      mem_if.rdata  = rst_data[i];
      #1;
      check_eq("rest_we", sr_write_enable, 1);
      check_eq("rest_waddr", sr_write_addr, i);
      check_eq("rest_wdata", sr_write_data, rst_data[i]);
      tick;
      mem_if.rvalid = 1'b0;
    end
    check_eq("rest_done", done, 1);
    check_eq("rest_done_rreq", mem_if.rreq, 0);
    tick;
    check_eq("rest_idle_busy", busy, 0);
    for (int i = 0; i < 4; i++) check_eq("rest_sr", sr_model[i], rst_data[i]);

    // Restore interrupted by reset in RWAIT of entry 2; stray rvalid in RREQ
    base_addr     = 16'h0200;
    start_restore = 1'b1;
    tick;
    start_restore = 1'b0;
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 24'h99;
    #1;
    check_eq("rreq_stray_we", sr_write_enable, 0);
    tick;
    mem_if.rdata = 24'h55;
    #1;
    check_eq("ab_we0", sr_write_enable, 1);
    tick;
    mem_if.rvalid = 1'b0;
    check_eq("ab_raddr1", mem_if.raddr, 16'h0201);
    tick;
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 24'h66;
    tick;
    mem_if.rvalid = 1'b0;
    check_eq("ab_raddr2", mem_if.raddr, 16'h0202);
    tick;
    check_eq("ab_rwait_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("ab_rst_busy", busy, 0);
    check_eq("ab_rst_done", done, 0);
    check_eq("ab_rst_rreq", mem_if.rreq, 0);
    check_eq("ab_rst_raddr", mem_if.raddr, 0);
    check_eq("ab_rst_we", sr_write_enable, 0);
    check_eq("ab_rst_wvalid", mem_if.wvalid, 0);
    tick;
    rst = 1'b0;
    tick;
    check_eq("ab_post_done", done, 0);
    check_eq("ab_post_busy", busy, 0);
    check_eq("ab_sr0", sr_model[0], 24'h55);
    check_eq("ab_sr1", sr_model[1], 24'h66);
    check_eq("ab_sr2", sr_model[2], 24'h0C);

    // Fresh restore after reset starts at index 0
    base_addr     = 16'h0300;
    start_restore = 1'b1;
    tick;
    start_restore = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("re_rreq", mem_if.rreq, 1);
      check_eq("re_raddr", mem_if.raddr, re_addr[i]);
      tick;
      mem_if.rvalid = 1'b1;
      mem_if.rdata  = re_data[i];
      #1;
      check_eq("re_waddr", sr_write_addr, i);
      tick;
      mem_if.rvalid = 1'b0;
    end
    check_eq("re_done", done, 1);
    tick;
    check_eq("re_idle_done", done, 0);
    for (int i = 0; i < 4; i++) check_eq("re_sr", sr_model[i], re_data[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
